// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the wide add/subtract sequencer: slice width,
// FSM state encoding and slice-index width helper.
package wide_add_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/wide_add_seq_add16_cin.sv
// 16-bit carry-select adder with carry-in: plain lower byte, upper byte
// precomputed for both carries and selected by the lower carry-out.
module add16_cin (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        co
);

    logic [8:0] lo;
    logic [8:0] hi0;
    logic [8:0] hi1;

    always_comb begin
        lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'b0, cin};
        hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
        hi1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;
        s   = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
        co  = lo[8] ? hi1[8] : hi0[8];
    end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle WORDS x 16-bit add/subtract, one slice per cycle through a
// single shared carry-select adder, with valid/ready on both sides.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SLICE_W*WORDS-1:0] a,
    input  logic [SLICE_W*WORDS-1:0] b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SLICE_W*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);

    localparam int W  = SLICE_W * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;

    assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

    add16_cin u_add (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .s   (slice_s),
        .co  (slice_co)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
                carry_d = slice_co;
                if (idx_q == LAST_IDX) begin
                    // b_q already holds ~b for subtract, so the sign test uses the adder's view of B.
                    cout_d      = slice_co;
                    ovf_d       = (a_q[W-1] == b_q[W-1]) && (slice_s[SLICE_W-1] != a_q[W-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq with WORDS=4: arithmetic corner cases,
// output backpressure and asynchronous reset in the middle of an operation.
module tb_wide_add_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int total;
    int bad;

    wide_add_seq #(.WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept, check latency of 4, check result, then complete the out handshake.
    task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic sv, input logic [63:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;

        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("c1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        run_op("c2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
        run_op("c3", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op("c4a", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("c4b", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Backpressure: first result held while a second operation waits on in_valid.
        @(negedge clk);
        a = 64'h0000_0001_0000_0002; b = 64'h0000_0003_0000_0004; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 64'h10; b = 64'h20;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_first_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_sum", sum, 64'h0000_0004_0000_0006);
            chk("bp_hold_cout", 64'(cout), 64'd0);
            chk("bp_hold_ovf", 64'(ovf), 64'd0);
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_busy", 64'(busy), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_second_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        chk("bp_second_sum", sum, 64'h30);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset while slice 2 is in flight.
        @(negedge clk);
        a = 64'h0000_0000_0000_FFFF; b = 64'h1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_partial_sum", sum, 64'h0000_0000_0001_0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", sum, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
            chk("post_rst_idle", 64'(busy), 64'd0);
        end
        run_op("c6", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
